// File: rtl/eth_pkg.sv
// Shared Ethernet receive/transmit definitions: framer FSM states, framing
// constants and the reflected CRC-32 parameters used by crc32_d8.
package eth_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    DST,
    HDR,
    PAY,
    DROP
  } rx_state_t;

  localparam logic [7:0]  ETH_PREAMBLE = 8'h55;
  localparam logic [7:0]  ETH_SFD      = 8'hD5;
  localparam logic [47:0] ETH_BCAST    = 48'hFFFF_FFFF_FFFF;

  localparam logic [31:0] CRC_POLY     = 32'hEDB8_8320;
  localparam logic [31:0] CRC_INIT     = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_RESIDUE  = 32'hDEBB_20E3;

  localparam int          ETH_FCS_LEN  = 4;

endpackage

// File: rtl/crc32_d8.sv
// Combinational next-state of the reflected Ethernet CRC-32 for one byte,
// LSB first. Shared by the receive checker and the transmit FCS generator.
module crc32_d8
  import eth_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data_in,
  output logic [31:0] crc_out
);

  logic [31:0] c;

  always_comb begin
    c = crc_in ^ {24'h000000, data_in};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    crc_out = c;
  end

endmodule

// File: rtl/gmii_rx_frame.sv
// GMII receive framer: strips preamble/SFD, filters on destination MAC, captures
// source MAC/EtherType and forwards payload minus FCS. Define GMII_RX_CRC_CHK_EN to check the FCS.
module gmii_rx_frame
  import eth_pkg::*;
#(
  parameter logic [47:0] BOARD_MAC   = 48'h00_11_22_33_44_55,
  parameter int          PRE_MIN     = 7,
  parameter int          MAX_PAYLOAD = 1500
) (
  input  logic        gmii_rx_clk,
  input  logic        rst,
  input  logic        gmii_rx_dv,
  input  logic [7:0]  gmii_rxd,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  output logic        rx_sof,
  output logic        rx_done,
  output logic        rx_err,
  output logic [15:0] rx_ethertype,
  output logic [47:0] rx_src_mac,
  output logic        rx_bcast
);

  localparam logic [2:0]  PRE_MIN_L = 3'(PRE_MIN);
  localparam logic [2:0]  FCS_LEN_L = 3'(ETH_FCS_LEN);
  localparam logic [10:0] MAX_PAY_L = 11'(MAX_PAYLOAD);

  rx_state_t   state, state_next;
  logic [2:0]  pre_cnt;
  logic [2:0]  hdr_cnt;
  logic [39:0] dst_sr;
  logic [55:0] hdr_sr;
  logic        bcast_pend;
  logic [31:0] dline;
  logic [2:0]  fill;
  logic [10:0] pay_cnt;
  logic        ovf;

  logic [47:0] dst_word;
  logic        dst_is_bcast;
  logic        dst_hit;
  logic        line_full;
  logic        pay_beat;
  logic        present;
  logic        ovf_hit;
  logic        crc_bad;
  logic        done_next;
  logic        err_next;

  assign dst_word     = {dst_sr, gmii_rxd};
  assign dst_is_bcast = (dst_word == ETH_BCAST);
  assign dst_hit      = dst_is_bcast || (dst_word == BOARD_MAC);
  assign line_full    = (fill == FCS_LEN_L);
  assign pay_beat     = (state == PAY) && gmii_rx_dv && line_full;
  assign present      = pay_beat && (pay_cnt < MAX_PAY_L);
  assign ovf_hit      = pay_beat && !present;

`ifdef GMII_RX_CRC_CHK_EN
  logic [31:0] crc_q;
  logic [31:0] crc_d;

  crc32_d8 u_crc (
    .crc_in  (crc_q),
    .data_in (gmii_rxd),
    .crc_out (crc_d)
  );

  // CRC covers everything after the SFD, FCS included, so a good frame leaves the residue.
  always_ff @(posedge gmii_rx_clk) begin
    if (rst) begin
      crc_q <= 32'h0;
    end else if (state == PRE) begin
      crc_q <= CRC_INIT;
    end else if (gmii_rx_dv && (state == DST || state == HDR || state == PAY)) begin
      crc_q <= crc_d;
    end
  end

  assign crc_bad = (crc_q != CRC_RESIDUE);
`else
  assign crc_bad = 1'b0;
`endif

  always_ff @(posedge gmii_rx_clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    done_next  = 1'b0;
    err_next   = 1'b0;
    case (state)
      IDLE: begin
        if (gmii_rx_dv) state_next = (gmii_rxd == ETH_PREAMBLE) ? PRE : DROP;
      end
      PRE: begin
        if (!gmii_rx_dv)                                      state_next = IDLE;
        else if (gmii_rxd == ETH_PREAMBLE)                    state_next = PRE;
        else if (gmii_rxd == ETH_SFD && pre_cnt >= PRE_MIN_L) state_next = DST;
        else                                                  state_next = DROP;
      end
      DST: begin
        if (!gmii_rx_dv) begin
          state_next = IDLE;
          done_next  = 1'b1;
          err_next   = 1'b1;
        end else if (hdr_cnt == 3'd5) begin
          state_next = dst_hit ? HDR : DROP;
        end
      end
      HDR: begin
        if (!gmii_rx_dv) begin
          state_next = IDLE;
          done_next  = 1'b1;
          err_next   = 1'b1;
        end else if (hdr_cnt == 3'd7) begin
          state_next = PAY;
        end
      end
      PAY: begin
        if (!gmii_rx_dv) begin
          state_next = IDLE;
          done_next  = 1'b1;
          err_next   = !line_full || ovf || crc_bad;
        end
      end
      DROP: begin
        if (!gmii_rx_dv) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // The 4-byte delay line always holds the newest bytes; whatever is left at dv fall is the FCS.
  always_ff @(posedge gmii_rx_clk) begin
    if (rst) begin
      rx_data      <= 8'h00;
      rx_valid     <= 1'b0;
      rx_sof       <= 1'b0;
      rx_done      <= 1'b0;
      rx_err       <= 1'b0;
      rx_ethertype <= 16'h0000;
      rx_src_mac   <= 48'h0;
      rx_bcast     <= 1'b0;
      pre_cnt      <= 3'd0;
      hdr_cnt      <= 3'd0;
      dst_sr       <= 40'h0;
      hdr_sr       <= 56'h0;
      bcast_pend   <= 1'b0;
      dline        <= 32'h0;
      fill         <= 3'd0;
      pay_cnt      <= 11'd0;
      ovf          <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      rx_sof   <= 1'b0;
      rx_done  <= done_next;
      rx_err   <= err_next;
      case (state)
        IDLE: begin
          pre_cnt <= 3'd1;
          hdr_cnt <= 3'd0;
          dline   <= 32'h0;
          fill    <= 3'd0;
          pay_cnt <= 11'd0;
          ovf     <= 1'b0;
        end
        PRE: begin
          if (gmii_rx_dv && gmii_rxd == ETH_PREAMBLE && pre_cnt != 3'd7)
            pre_cnt <= pre_cnt + 3'd1;
        end
        DST: begin
          if (gmii_rx_dv) begin
            dst_sr     <= {dst_sr[31:0], gmii_rxd};
            bcast_pend <= dst_is_bcast;
            hdr_cnt    <= (hdr_cnt == 3'd5) ? 3'd0 : hdr_cnt + 3'd1;
          end
        end
        HDR: begin
          if (gmii_rx_dv) begin
            hdr_sr  <= {hdr_sr[47:0], gmii_rxd};
            hdr_cnt <= hdr_cnt + 3'd1;
            if (hdr_cnt == 3'd7) begin
              rx_src_mac   <= hdr_sr[55:8];
              rx_ethertype <= {hdr_sr[7:0], gmii_rxd};
              rx_bcast     <= bcast_pend;
            end
          end
        end
        PAY: begin
          if (gmii_rx_dv) begin
            dline <= {dline[23:0], gmii_rxd};
            if (!line_full) fill <= fill + 3'd1;
            if (present) begin
              rx_data  <= dline[31:24];
              rx_valid <= 1'b1;
              rx_sof   <= (pay_cnt == 11'd0);
              if (pay_cnt != 11'h7FF) pay_cnt <= pay_cnt + 11'd1;
            end
            if (ovf_hit) ovf <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
